// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
package mult_pkg;

    // Control states of the multiplier sequencer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Radix-4 Booth digit selected from one 3-bit multiplier window.
    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } digit_t;

    // Number of radix-4 iterations for a given operand width.
    function automatic int calc_steps(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// Booth radix-4 recoder: window {b[i+1], b[i], b[i-1]} -> digit -> addend.
module booth_r4_recode
    import mult_pkg::*;
#(
    parameter int EXT = 34
) (
    input  logic [2:0]     window,
    input  logic [EXT-1:0] a,
    output logic [EXT:0]   addend
);

    digit_t         digit;
    logic [EXT:0]   a1;
    logic [EXT:0]   a2;

    // Decode the window into a signed Booth digit.
    always_comb begin
        digit = ZERO;
        case (window)
            3'b000, 3'b111: digit = ZERO;
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            default:        digit = NEG1;
        endcase
    end

    // Select 0, +-A or +-2A at EXT+1 bits.
    always_comb begin
        a1     = {a[EXT-1], a};
        a2     = {a, 1'b0};
        addend = '0;
        case (digit)
            ZERO:    addend = '0;
            POS1:    addend = a1;
            POS2:    addend = a2;
            NEG1:    addend = -a1;
            NEG2:    addend = -a2;
            default: addend = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_mult.sv
// Iterative radix-4 Booth multiplier with valid/ready handshakes,
// signed/unsigned mode and a zero-operand early-out.
module booth_r4_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int EXT   = WIDTH + 2;
    localparam int ACCW  = 2 * EXT + 1;
    localparam int STEPS = calc_steps(WIDTH);
    localparam int CW    = $clog2(STEPS + 1);

    state_t             state_q, state_d;
    logic [EXT-1:0]     a_q, a_d;
    logic [ACCW-1:0]    acc_q, acc_d;
    logic               extra_q, extra_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    logic [EXT:0]       addend;
    logic [EXT:0]       sum;
    logic [ACCW-1:0]    pre_shift;
    logic [ACCW-1:0]    shifted;
    logic               zero_op;

    booth_r4_recode #(
        .EXT (EXT)
    ) u_recode (
        .window (({acc_q[1:0], extra_q})),
        .a      (a_q),
        .addend (addend)
    );

    // One Booth step: add into the upper EXT+1 bits, then arithmetic shift by 2.
    always_comb begin
        sum       = acc_q[ACCW-1:EXT] + addend;
        pre_shift = {sum, acc_q[EXT-1:0]};
        shifted   = {{2{pre_shift[ACCW-1]}}, pre_shift[ACCW-1:2]};
        // Before the first step the low EXT bits still hold the latched multiplier.
        zero_op   = (a_q == '0) || (acc_q[EXT-1:0] == '0);
    end

    // Next-state logic for the sequencer, datapath and registered outputs.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        acc_d       = acc_q;
        extra_d     = extra_q;
        count_d     = count_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = {{2{is_signed & multiplicand[WIDTH-1]}}, multiplicand};
                    acc_d      = {{(EXT+1){1'b0}},
                                  {2{is_signed & multiplier[WIDTH-1]}}, multiplier};
                    extra_d    = 1'b0;
                    count_d    = '0;
                    in_ready_d = 1'b0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                if ((count_q == '0) && zero_op) begin
                    product_d   = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    acc_d   = shifted;
                    extra_d = acc_q[1];
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(STEPS - 1)) begin
                        product_d   = shifted[2*WIDTH-1:0];
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            acc_q       <= '0;
            extra_q     <= 1'b0;
            count_q     <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            acc_q       <= acc_d;
            extra_q     <= extra_d;
            count_q     <= count_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule

// File: tb/tb_booth_r4_mult.sv
// Scoreboard bench for booth_r4_mult at WIDTH=32 and WIDTH=8.
module tb_booth_r4_mult;

    typedef struct {
        logic [63:0] prod;
        int          lat;
        int          acc;
    } item_t;

    logic        clk;
    logic        rst_n;
    int          cyc;
    int          total;
    int          bad;

    // WIDTH=32 instance signals
    logic        in_valid, in_ready, is_signed, out_valid, out_ready;
    logic [31:0] multiplicand, multiplier;
    logic [63:0] product;

    // WIDTH=8 instance signals
    logic        in_valid8, in_ready8, is_signed8, out_valid8, out_ready8;
    logic [7:0]  multiplicand8, multiplier8;
    logic [15:0] product8;

    item_t q32[$];
    item_t q8[$];
    bit    seen32;
    bit    seen8;

    booth_r4_mult #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .is_signed    (is_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product)
    );

    booth_r4_mult #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid8),
        .in_ready     (in_ready8),
        .is_signed    (is_signed8),
        .multiplicand (multiplicand8),
        .multiplier   (multiplier8),
        .out_valid    (out_valid8),
        .out_ready    (out_ready8),
        .product      (product8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the 32-bit instance: latency on first valid, product on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen32 = 1'b0;
        end else if (out_valid) begin
            if (!seen32) begin
                seen32 = 1'b1;
                if (q32.size() == 0) begin
                    check("unexpected_out32", 64'd1, 64'd0);
                end else begin
                    check("lat32", 64'(cyc - q32[0].acc), 64'(q32[0].lat));
                    check("ready_vs_valid32", 64'(in_ready), 64'd0);
                end
            end
            if (out_ready && q32.size() != 0) begin
                check("prod32", product, q32[0].prod);
                void'(q32.pop_front());
                seen32 = 1'b0;
            end
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen8 = 1'b0;
        end else if (out_valid8) begin
            if (!seen8) begin
                seen8 = 1'b1;
                if (q8.size() == 0) begin
                    check("unexpected_out8", 64'd1, 64'd0);
                end else begin
                    check("lat8", 64'(cyc - q8[0].acc), 64'(q8[0].lat));
                    check("ready_vs_valid8", 64'(in_ready8), 64'd0);
                end
            end
            if (out_ready8 && q8.size() != 0) begin
                check("prod8", 64'(product8), q8[0].prod);
                void'(q8.pop_front());
                seen8 = 1'b0;
            end
        end
    end

    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [63:0] exp, input int lat);
        int n;
        @(posedge clk); #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_wait32", 64'd0, 64'd1);
        in_valid     = 1'b1;
        multiplicand = a;
        multiplier   = b;
        is_signed    = s;
        q32.push_back('{exp, lat, cyc + 1});
        @(posedge clk); #1;
        in_valid     = 1'b0;
        multiplicand = 32'hDEADBEEF;
        multiplier   = 32'h13579BDF;
        is_signed    = ~s;
    endtask

    task automatic finish32(input logic [63:0] exp, input int hold);
        int n;
        check("busy_ready32", 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) check("timeout32", 64'd0, 64'd1);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_prod", product, exp);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_in_ready32", 64'(in_ready), 64'd1);
        check("idle_out_valid32", 64'(out_valid), 64'd0);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int          n;
        logic [15:0] exp;
        int          lat;
        if (s) exp = 16'(int'($signed(a)) * int'($signed(b)));
        else   exp = 16'(int'(a) * int'(b));
        lat = (a == 8'd0 || b == 8'd0) ? 1 : 5;
        @(posedge clk); #1;
        n = 0;
        while (!in_ready8 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready8) check("in_ready_wait8", 64'd0, 64'd1);
        in_valid8     = 1'b1;
        multiplicand8 = a;
        multiplier8   = b;
        is_signed8    = s;
        q8.push_back('{64'(exp), lat, cyc + 1});
        @(posedge clk); #1;
        in_valid8     = 1'b0;
        multiplicand8 = 8'(~a);
        n = 0;
        while (!out_valid8 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid8) check("timeout8", 64'd0, 64'd1);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; total = 0; bad = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; is_signed = 1'b0;
        multiplicand = '0; multiplier = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; is_signed8 = 1'b0;
        multiplicand8 = '0; multiplier8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_in_ready8", 64'(in_ready8), 64'd1);
        rst_n = 1'b1;

        // Directed 32-bit vectors with hand-computed products.
        issue32(32'hFFFFFFFD, 32'd7, 1'b1, 64'hFFFFFFFF_FFFFFFEB, 17);
        finish32(64'hFFFFFFFF_FFFFFFEB, 3);
        issue32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, 17);
        finish32(64'hFFFFFFFE_00000001, 0);
        issue32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001, 17);
        finish32(64'h00000000_00000001, 0);
        issue32(32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, 17);
        finish32(64'h40000000_00000000, 0);
        issue32(32'h80000000, 32'h80000000, 1'b0, 64'h40000000_00000000, 17);
        finish32(64'h40000000_00000000, 0);
        issue32(32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC0000000_80000000, 17);
        finish32(64'hC0000000_80000000, 0);
        issue32(32'h7FFFFFFF, 32'h80000000, 1'b0, 64'h3FFFFFFF_80000000, 17);
        finish32(64'h3FFFFFFF_80000000, 0);
        issue32(32'h00010000, 32'h00010000, 1'b1, 64'h00000001_00000000, 17);
        finish32(64'h00000001_00000000, 0);

        // Early-out with backpressure, then the zero-multiplier side.
        issue32(32'd0, 32'h12345678, 1'b1, 64'd0, 1);
        finish32(64'd0, 10);
        issue32(32'h12345678, 32'd0, 1'b0, 64'd0, 1);
        finish32(64'd0, 0);

        // Reset in the middle of an operation: no output, clean restart.
        @(posedge clk); #1;
        in_valid = 1'b1; multiplicand = 32'd5; multiplier = 32'd9; is_signed = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_product", product, 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        issue32(32'd6, 32'd7, 1'b1, 64'd42, 17);
        finish32(64'd42, 0);

        // WIDTH=8: directed corners then random pairs in both modes.
        run8(8'h80, 8'h80, 1'b1);
        run8(8'hFF, 8'hFF, 1'b0);
        run8(8'hFF, 8'hFF, 1'b1);
        run8(8'h00, 8'h5A, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            run8(8'($urandom), 8'($urandom), 1'(i % 2));
        end

        repeat (3) @(posedge clk);
        #1;
        check("q32_drained", 64'(q32.size()), 64'd0);
        check("q8_drained", 64'(q8.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
